// File: rtl/ppu_reg_port.sv
// ppu_reg_port
// CPU-facing register file of the NES PPU. Responds to CPU accesses in the
// mirrored $2000-$3FFF window (eight registers, mirrored every 8 bytes).
// It owns the VRAM address pointer (v), the temporary address (t), the shared
// write toggle (w), the buffered PPUDATA read path and the vblank/NMI logic.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   bus_en/addr/write/d_in: one-cycle CPU access strobe, address, direction, data
//   d_out                 : registered read data (valid the cycle after a read)
//   vblank_set/vblank_clr : pulses from the timing generator
//   spr0_hit/spr_ovf      : renderer status levels
//   nmi                   : registered NMI request level
//   ppu_ctrl/ppu_mask     : CTRL / MASK contents
//   scroll_x/scroll_y     : PPUSCROLL contents
//   vram_*                : VRAM port (strobes one cycle, read data one cycle later)
//   oam_*                 : OAM write port and OAMADDR value
//   ovr_err               : pulse when a PPUDATA access is dropped
module ppu_reg_port #(
  parameter logic [2:0] REG_BASE = 3'b001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_en,
  input  logic [15:0] addr,
  input  logic        write,
  input  logic [7:0]  d_in,
  output logic [7:0]  d_out,
  input  logic        vblank_set,
  input  logic        vblank_clr,
  input  logic        spr0_hit,
  input  logic        spr_ovf,
  output logic        nmi,
  output logic [7:0]  ppu_ctrl,
  output logic [7:0]  ppu_mask,
  output logic [7:0]  scroll_x,
  output logic [7:0]  scroll_y,
  output logic [13:0] vram_addr,
  output logic [7:0]  vram_wdata,
  output logic        vram_we,
  output logic        vram_re,
  input  logic [7:0]  vram_rdata,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        oam_we,
  output logic        ovr_err
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WR       = 2'd1,
    S_RD_ISSUE = 2'd2,
    S_RD_WAIT  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  ctrl_q, ctrl_d;
  logic [7:0]  mask_q, mask_d;
  logic [7:0]  sx_q, sx_d;
  logic [7:0]  sy_q, sy_d;
  logic [7:0]  oam_addr_q, oam_addr_d;
  logic [7:0]  oam_wdata_q, oam_wdata_d;
  logic        oam_we_q, oam_we_d;
  logic [13:0] v_q, v_d;
  logic [13:0] t_q, t_d;
  logic        w_q, w_d;
  logic [13:0] hold_q, hold_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        vflag_q, vflag_d;
  logic [7:0]  rbuf_q, rbuf_d;
  logic [7:0]  io_q, io_d;
  logic [7:0]  dout_q, dout_d;
  logic        nmi_q, nmi_d;
  logic        ovr_q, ovr_d;

  logic        acc, is_rd, is_wr, status_rd;
  logic        data_acc, data_ok, data_drop;
  logic [2:0]  rsel;
  logic [13:0] inc;
  logic [7:0]  rd_val;

  // Bits that do not take part in decode; low t byte is only ever copied to v
  // directly from d_in, so the stored copy is never read back.
  logic        unused_bits;
  assign unused_bits = ^{addr[12:3], t_q[7:0]};

  assign acc       = bus_en && (addr[15:13] == REG_BASE);
  assign rsel      = addr[2:0];
  assign is_rd     = acc && !write;
  assign is_wr     = acc && write;
  assign status_rd = is_rd && (rsel == 3'd2);
  assign data_acc  = acc && (rsel == 3'd7);
  assign data_ok   = data_acc && (state_q == S_IDLE);
  assign data_drop = data_acc && (state_q != S_IDLE);
  assign inc       = ctrl_q[2] ? 14'd32 : 14'd1;

  // A STATUS read coinciding with vblank_set reports the flag as still clear.
  always_comb begin
    rd_val = io_q;
    case (rsel)
      3'd2:    rd_val = {vflag_q & ~vblank_set, spr0_hit, spr_ovf, io_q[4:0]};
      3'd7:    rd_val = rbuf_q;
      default: rd_val = io_q;
    endcase
  end

  // PPUDATA sequencer
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (data_ok) begin
          state_d = write ? S_WR : S_RD_ISSUE;
        end
      end
      S_WR:       state_d = S_IDLE;
      S_RD_ISSUE: state_d = S_RD_WAIT;
      S_RD_WAIT:  state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ctrl_d      = ctrl_q;
    mask_d      = mask_q;
    sx_d        = sx_q;
    sy_d        = sy_q;
    oam_wdata_d = oam_wdata_q;
    oam_we_d    = 1'b0;
    v_d         = v_q;
    t_d         = t_q;
    w_d         = w_q;
    hold_d      = hold_q;
    wdata_d     = wdata_q;
    rbuf_d      = rbuf_q;
    io_d        = io_q;
    dout_d      = dout_q;
    ovr_d       = data_drop;
    nmi_d       = vflag_q & ctrl_q[7];

    // The OAMADDR increment is applied one cycle late so the address stays
    // visible alongside oam_we; an OAMADDR write in that cycle takes priority.
    oam_addr_d = oam_we_q ? oam_addr_q + 8'd1 : oam_addr_q;

    // Set wins over clear; a STATUS read acts as a clear.
    if (vblank_set) begin
      vflag_d = 1'b1;
    end else if (vblank_clr || status_rd) begin
      vflag_d = 1'b0;
    end else begin
      vflag_d = vflag_q;
    end

    if (state_q == S_RD_WAIT) begin
      rbuf_d = vram_rdata;
    end

    if (is_wr) begin
      io_d = d_in;
      case (rsel)
        3'd0: ctrl_d = d_in;
        3'd1: mask_d = d_in;
        3'd3: oam_addr_d = d_in;
        3'd4: begin
          oam_we_d    = 1'b1;
          oam_wdata_d = d_in;
        end
        3'd5: begin
          if (w_q) sy_d = d_in;
          else     sx_d = d_in;
          w_d = ~w_q;
        end
        3'd6: begin
          if (w_q) begin
            t_d[7:0] = d_in;
            v_d      = {t_q[13:8], d_in};
          end else begin
            t_d[13:8] = d_in[5:0];
          end
          w_d = ~w_q;
        end
        default: begin
        end
      endcase
    end

    if (is_rd && !data_drop) begin
      io_d   = rd_val;
      dout_d = rd_val;
    end

    if (status_rd) begin
      w_d = 1'b0;
    end

    // Accepted PPUDATA access: remember the pre-increment address for the
    // strobe cycle, then step v.
    if (data_ok) begin
      hold_d = v_q;
      v_d    = v_q + inc;
      if (write) begin
        wdata_d = d_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ctrl_q      <= 8'h00;
      mask_q      <= 8'h00;
      sx_q        <= 8'h00;
      sy_q        <= 8'h00;
      oam_addr_q  <= 8'h00;
      oam_wdata_q <= 8'h00;
      oam_we_q    <= 1'b0;
      v_q         <= 14'h0000;
      t_q         <= 14'h0000;
      w_q         <= 1'b0;
      hold_q      <= 14'h0000;
      wdata_q     <= 8'h00;
      vflag_q     <= 1'b0;
      rbuf_q      <= 8'h00;
      io_q        <= 8'h00;
      dout_q      <= 8'h00;
      nmi_q       <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      mask_q      <= mask_d;
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      oam_addr_q  <= oam_addr_d;
      oam_wdata_q <= oam_wdata_d;
      oam_we_q    <= oam_we_d;
      v_q         <= v_d;
      t_q         <= t_d;
      w_q         <= w_d;
      hold_q      <= hold_d;
      wdata_q     <= wdata_d;
      vflag_q     <= vflag_d;
      rbuf_q      <= rbuf_d;
      io_q        <= io_d;
      dout_q      <= dout_d;
      nmi_q       <= nmi_d;
      ovr_q       <= ovr_d;
    end
  end

  assign d_out      = dout_q;
  assign nmi        = nmi_q;
  assign ppu_ctrl   = ctrl_q;
  assign ppu_mask   = mask_q;
  assign scroll_x   = sx_q;
  assign scroll_y   = sy_q;
  assign vram_we    = (state_q == S_WR);
  assign vram_re    = (state_q == S_RD_ISSUE);
  assign vram_addr  = (vram_we || vram_re) ? hold_q : v_q;
  assign vram_wdata = wdata_q;
  assign oam_addr   = oam_addr_q;
  assign oam_wdata  = oam_wdata_q;
  assign oam_we     = oam_we_q;
  assign ovr_err    = ovr_q;

endmodule

// File: tb/tb_ppu_reg_port.sv
// Bench for ppu_reg_port: directed test-plan steps followed by a randomized
// access stream, all checked against a register-level behavioural model.
module tb_ppu_reg_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        bus_en;
  logic [15:0] addr;
  logic        write;
  logic [7:0]  d_in;
  logic [7:0]  d_out;
  logic        vblank_set, vblank_clr, spr0_hit, spr_ovf;
  logic        nmi;
  logic [7:0]  ppu_ctrl, ppu_mask, scroll_x, scroll_y;
  logic [13:0] vram_addr;
  logic [7:0]  vram_wdata;
  logic        vram_we, vram_re;
  logic [7:0]  vram_rdata;
  logic [7:0]  oam_addr, oam_wdata;
  logic        oam_we, ovr_err;

  always #5 clk = ~clk;

  ppu_reg_port #(.REG_BASE(3'b001)) dut (
    .clk(clk), .reset(reset), .bus_en(bus_en), .addr(addr), .write(write),
    .d_in(d_in), .d_out(d_out), .vblank_set(vblank_set), .vblank_clr(vblank_clr),
    .spr0_hit(spr0_hit), .spr_ovf(spr_ovf), .nmi(nmi), .ppu_ctrl(ppu_ctrl),
    .ppu_mask(ppu_mask), .scroll_x(scroll_x), .scroll_y(scroll_y),
    .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_we(vram_we),
    .vram_re(vram_re), .vram_rdata(vram_rdata), .oam_addr(oam_addr),
    .oam_wdata(oam_wdata), .oam_we(oam_we), .ovr_err(ovr_err)
  );

  // Default VRAM contents, with the two locations the test plan pins down.
  function automatic logic [7:0] vinit(input logic [13:0] a);
    if (a == 14'h3FFF) return 8'h11;
    if (a == 14'h001F) return 8'h22;
    return a[7:0] ^ {2'b00, a[13:8]} ^ 8'hA5;
  endfunction

  // VRAM responder driven by the DUT's strobes.
  bit [7:0] mem [0:16383];
  bit       wrt [0:16383];
  always @(posedge clk) begin
    if (vram_re) vram_rdata <= wrt[vram_addr] ? mem[vram_addr] : vinit(vram_addr);
    if (vram_we) begin
      mem[vram_addr] <= vram_wdata;
      wrt[vram_addr] <= 1'b1;
    end
  end

  // Reference model state
  bit [7:0]  mmem [0:16383];
  bit        mwrt [0:16383];
  logic [7:0]  m_ctrl, m_mask, m_sx, m_sy, m_oam, m_io, m_dout, m_rbuf;
  logic [13:0] m_v, m_t;
  logic        m_w, m_vflag;
  int          cyc = 0;
  int          next_ok = 0;
  int          tests = 0;
  int          fails = 0;

  function automatic logic [7:0] mread(input logic [13:0] a);
    return mwrt[a] ? mmem[a] : vinit(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    bus_en = 1'b0;
    reset  = 1'b1;
    step();
    step();
    reset  = 1'b0;
    m_ctrl = 0; m_mask = 0; m_sx = 0; m_sy = 0; m_oam = 0; m_io = 0;
    m_dout = 0; m_rbuf = 0; m_v = 0; m_t = 0; m_w = 0; m_vflag = 0;
    next_ok = 0;
  endtask

  // One CPU access in the current cycle; outputs are checked in the next one.
  task automatic access(input bit wr, input logic [2:0] r, input logic [7:0] d);
    logic [9:0]  mid;
    logic [7:0]  val;
    logic [13:0] old_v, inc;
    logic [7:0]  old_oam;
    bit          drop;
    mid    = 10'($urandom);
    bus_en = 1'b1;
    write  = wr;
    addr   = {3'b001, mid, r};
    d_in   = d;
    drop   = (r == 3'd7) && (cyc < next_ok);
    old_v  = m_v;
    old_oam = m_oam;
    inc    = m_ctrl[2] ? 14'd32 : 14'd1;
    if (wr) begin
      m_io = d;
      case (r)
        3'd0: m_ctrl = d;
        3'd1: m_mask = d;
        3'd3: m_oam = d;
        3'd4: m_oam = m_oam + 8'd1;
        3'd5: begin if (m_w) m_sy = d; else m_sx = d; m_w = ~m_w; end
        3'd6: begin
          if (m_w) begin m_t[7:0] = d; m_v = m_t; end
          else m_t[13:8] = d[5:0];
          m_w = ~m_w;
        end
        3'd7: if (!drop) begin
          mmem[m_v] = d; mwrt[m_v] = 1'b1;
          m_v = m_v + inc; next_ok = cyc + 2;
        end
        default: ;
      endcase
    end else if (!drop) begin
      case (r)
        3'd2:    val = {m_vflag & ~vblank_set, spr0_hit, spr_ovf, m_io[4:0]};
        3'd7:    val = m_rbuf;
        default: val = m_io;
      endcase
      if (r == 3'd2) begin m_vflag = vblank_set; m_w = 1'b0; end
      if (r == 3'd7) begin
        m_rbuf = mread(m_v); m_v = m_v + inc; next_ok = cyc + 3;
      end
      m_io = val;
      m_dout = val;
    end
    step();
    bus_en = 1'b0;
    $display("[TB] t=%0t %s reg%0d data=%02h drop=%0d d_out=%02h", $time,
             wr ? "WR" : "RD", r, d, drop, d_out);
    if (r == 3'd7) chk("ovr_err", ovr_err, drop);
    if (!wr) chk("d_out", d_out, m_dout);
    if (r == 3'd7 && !drop) begin
      chk("vram_addr_strobe", vram_addr, old_v);
      if (wr) begin
        chk("vram_we", vram_we, 1);
        chk("vram_wdata", vram_wdata, d);
      end else begin
        chk("vram_re", vram_re, 1);
      end
    end
    if (wr && r == 3'd4) begin
      chk("oam_we", oam_we, 1);
      chk("oam_addr_pre", oam_addr, old_oam);
      chk("oam_wdata", oam_wdata, d);
    end
    if (wr && r == 3'd0) chk("ppu_ctrl", ppu_ctrl, m_ctrl);
    if (wr && r == 3'd1) chk("ppu_mask", ppu_mask, m_mask);
    if (wr && r == 3'd5) begin
      chk("scroll_x", scroll_x, m_sx);
      chk("scroll_y", scroll_y, m_sy);
    end
  endtask

  // Registered outputs once at least one idle cycle has passed.
  task automatic settle();
    chk("s_ppu_ctrl", ppu_ctrl, m_ctrl);
    chk("s_ppu_mask", ppu_mask, m_mask);
    chk("s_scroll_x", scroll_x, m_sx);
    chk("s_scroll_y", scroll_y, m_sy);
    chk("s_oam_addr", oam_addr, m_oam);
    chk("s_nmi", nmi, m_vflag & m_ctrl[7]);
  endtask

  task automatic pulse(input bit set);
    vblank_set = set;
    vblank_clr = ~set;
    step();
    vblank_set = 1'b0;
    vblank_clr = 1'b0;
    m_vflag = set;
    $display("[TB] t=%0t vblank_%s", $time, set ? "set" : "clr");
  endtask

  initial begin
    bus_en = 0; addr = 0; write = 0; d_in = 0;
    vblank_set = 0; vblank_clr = 0; spr0_hit = 0; spr_ovf = 0;
    reset = 1;
    do_reset();

    // Reset state
    chk("rst_d_out", d_out, 8'h00);
    chk("rst_nmi", nmi, 0);
    chk("rst_vram_addr", vram_addr, 14'h0000);
    chk("rst_vram_we", vram_we, 0);
    chk("rst_vram_re", vram_re, 0);
    chk("rst_oam_we", oam_we, 0);
    chk("rst_ovr_err", ovr_err, 0);
    access(0, 3'd2, 8'h00);
    chk("tp1_status", d_out, 8'h00);
    chk("tp1_nmi", nmi, 0);
    chk("tp1_vram_addr", vram_addr, 14'h0000);

    // ADDR 21/08 then DATA writes
    access(1, 3'd6, 8'h21);
    access(1, 3'd6, 8'h08);
    access(1, 3'd7, 8'hAB);
    chk("tp2_addr", vram_addr, 14'h2108);
    chk("tp2_data", vram_wdata, 8'hAB);
    step();
    access(1, 3'd7, 8'hCD);
    chk("tp2_addr_next", vram_addr, 14'h2109);

    // +32 increment with wrap across 3FFF
    access(1, 3'd0, 8'h04);
    access(1, 3'd6, 8'h3F);
    access(1, 3'd6, 8'hFF);
    access(0, 3'd7, 8'h00);
    chk("tp3_first", d_out, 8'h00);
    step(); step();
    access(0, 3'd7, 8'h00);
    chk("tp3_second", d_out, 8'h11);
    step(); step(); step();
    chk("tp3_final_v", vram_addr, 14'h003F);

    // Back-to-back DATA reads: second one dropped
    access(0, 3'd7, 8'h00);
    access(0, 3'd7, 8'h00);
    chk("tp4_d_out_held", d_out, 8'h22);
    step();
    chk("tp4_ovr_once", ovr_err, 0);
    step(); step();
    chk("tp4_v_once", vram_addr, 14'h005F);

    // NMI, STATUS clears vflag and w
    access(1, 3'd5, 8'h33);
    access(1, 3'd0, 8'h80);
    pulse(1);
    step();
    chk("tp5_nmi_on", nmi, 1);
    access(0, 3'd2, 8'h00);
    chk("tp5_status_bit7", d_out[7], 1);
    step();
    chk("tp5_nmi_off", nmi, 0);
    access(1, 3'd5, 8'h05);
    chk("tp5_scroll_x", scroll_x, 8'h05);

    // STATUS read coinciding with vblank_set
    pulse(1);
    step();
    vblank_set = 1'b1;
    access(0, 3'd2, 8'h00);
    vblank_set = 1'b0;
    chk("coin_bit7", d_out[7], 0);
    access(0, 3'd2, 8'h00);
    chk("coin_vflag_kept", d_out[7], 1);

    // Reset clears w
    access(1, 3'd5, 8'h01);
    do_reset();
    access(1, 3'd5, 8'h07);
    chk("tp6_scroll_x", scroll_x, 8'h07);

    // Reset during a buffer refill leaves rbuf at 0
    access(1, 3'd6, 8'h01);
    access(1, 3'd6, 8'h00);
    access(0, 3'd7, 8'h00);
    step(); step();
    access(0, 3'd7, 8'h00);
    do_reset();
    access(0, 3'd7, 8'h00);
    chk("midfill_rbuf", d_out, 8'h00);
    step(); step(); step();
    settle();

    // Randomized stream
    for (int i = 0; i < 250; i++) begin
      int gap;
      int kind;
      kind = $urandom_range(0, 19);
      if (kind == 0) begin
        // Access outside the register window must be ignored
        bus_en = 1'b1; write = 1'b1; d_in = 8'($urandom);
        addr = {3'b011, 10'($urandom), 3'($urandom)};
        step();
        bus_en = 1'b0;
      end else begin
        access(1'($urandom), 3'($urandom), 8'($urandom));
      end
      gap = $urandom_range(0, 3);
      repeat (gap) step();
      if (gap > 0) settle();
      if ($urandom_range(0, 7) == 0) begin
        spr0_hit = 1'($urandom);
        spr_ovf  = 1'($urandom);
        pulse(1'($urandom));
        step();
        settle();
      end
    end

    step(); step(); step();
    chk("final_vram_addr", vram_addr, m_v);
    settle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
